// File: rtl/dma_arb_pkg.sv
// Shared widths, types and FSM state encoding for the DMA channel arbiter.
// No logic; purely declarations.
// Not applicable (no datapath).
package dma_arb_pkg;

    localparam int ADDR_WIDTH = 64;
    localparam int SIZE_WIDTH = 43;
    localparam int DATA_WIDTH = 512;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [SIZE_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        XFER   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dma_rr_channel.sv
// One DMA channel shared round-robin by two requesters, one whole transfer per grant.
// Latency: go sampled -> dma_go two cycles later; completion -> done one cycle later.
// Backpressure: beats counted only when the top level forwards an accepted beat.
module dma_rr_channel
    import dma_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int SIZE_W = SIZE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_go,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][SIZE_W-1:0] req_size,
    input  logic                   beat_acc,
    input  logic                   dma_done,
    output logic                   xfer_open,
    output logic                   grant,
    output logic                   dma_go,
    output logic [ADDR_W-1:0]      dma_addr,
    output logic [SIZE_W-1:0]      dma_size,
    output logic [1:0]             done,
    output logic [1:0]             err
);

    arb_state_t               state;
    logic [1:0]               pending;
    logic [1:0][ADDR_W-1:0]   lat_addr;
    logic [1:0][SIZE_W-1:0]   lat_size;
    logic                     tie_ptr;
    logic [SIZE_W-1:0]        beats;
    logic [1:0]               go_ok;
    logic [1:0]               grant_clr;
    logic                     winner;
    logic                     busy;

    // Accept a go only from a requester that is neither queued nor currently served.
    always_comb begin
        busy      = (state != IDLE);
        go_ok[0]  = req_go[0] & ~pending[0] & ~(busy & ~grant);
        go_ok[1]  = req_go[1] & ~pending[1] & ~(busy & grant);
        winner    = (&pending) ? tie_ptr : ~pending[0];
        grant_clr = 2'b00;
        if (state == IDLE && |pending)
            grant_clr = winner ? 2'b10 : 2'b01;
    end

    // Request capture: pending flags, latched address/size, sticky error on rejected go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 2'b00;
            lat_addr <= '0;
            lat_size <= '0;
            err      <= 2'b00;
        end else begin
            if (go_ok[0]) begin
                lat_addr[0] <= req_addr[0];
                lat_size[0] <= req_size[0];
            end
            if (go_ok[1]) begin
                lat_addr[1] <= req_addr[1];
                lat_size[1] <= req_size[1];
            end
            err     <= err | (req_go & ~go_ok);
            pending <= (pending & ~grant_clr) | go_ok;
        end
    end

    // Channel FSM: grant, launch, count beats, and post completion to the owner.
    // The tie pointer only moves on a contended decision, so the loser of a tie wins the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            tie_ptr  <= 1'b0;
            beats    <= '0;
            dma_addr <= '0;
            dma_size <= '0;
            done     <= 2'b00;
        end else begin
            done <= done & ~go_ok;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant    <= winner;
                        dma_addr <= lat_addr[winner];
                        dma_size <= lat_size[winner];
                        if (&pending)
                            tie_ptr <= ~winner;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    beats <= '0;
                    if (dma_size == '0) begin
                        done[grant] <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (beat_acc)
                        beats <= beats + 1'b1;
                    // The beat match gates dma_done so a level left over from the prior transfer is ignored.
                    if (beats == dma_size && dma_done) begin
                        done[grant] <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dma_go    = (state == LAUNCH) && (dma_size != '0);
    assign xfer_open = (state == XFER) && (beats != dma_size);

endmodule

// File: rtl/dma_channel_arbiter.sv
// Shares the AFU DMA read and write channels between two requesters, each channel round-robin.
// Latency: requester go -> dma go two cycles; data paths are combinational pass-through.
// Backpressure: only the granted requester sees not-empty/not-full; other enables are dropped.
module dma_channel_arbiter #(
    parameter int ADDR_WIDTH = dma_arb_pkg::ADDR_WIDTH,
    parameter int SIZE_WIDTH = dma_arb_pkg::SIZE_WIDTH,
    parameter int DATA_WIDTH = dma_arb_pkg::DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_rd_go,
    input  logic [1:0][ADDR_WIDTH-1:0] req_rd_addr,
    input  logic [1:0][SIZE_WIDTH-1:0] req_rd_size,
    input  logic [1:0]                 req_rd_en,
    output logic [1:0]                 req_rd_empty,
    output logic [DATA_WIDTH-1:0]      req_rd_data,
    output logic [1:0]                 req_rd_done,
    input  logic [1:0]                 req_wr_go,
    input  logic [1:0][ADDR_WIDTH-1:0] req_wr_addr,
    input  logic [1:0][SIZE_WIDTH-1:0] req_wr_size,
    input  logic [1:0]                 req_wr_en,
    input  logic [1:0][DATA_WIDTH-1:0] req_wr_data,
    output logic [1:0]                 req_wr_full,
    output logic [1:0]                 req_wr_done,
    output logic [1:0]                 req_err,
    output logic                       dma_rd_go,
    output logic [ADDR_WIDTH-1:0]      dma_rd_addr,
    output logic [SIZE_WIDTH-1:0]      dma_rd_size,
    output logic                       dma_rd_en,
    input  logic                       dma_rd_empty,
    input  logic [DATA_WIDTH-1:0]      dma_rd_data,
    input  logic                       dma_rd_done,
    output logic                       dma_wr_go,
    output logic [ADDR_WIDTH-1:0]      dma_wr_addr,
    output logic [SIZE_WIDTH-1:0]      dma_wr_size,
    output logic                       dma_wr_en,
    output logic [DATA_WIDTH-1:0]      dma_wr_data,
    input  logic                       dma_wr_full,
    input  logic                       dma_wr_done
);

    logic       rd_open, rd_g, wr_open, wr_g;
    logic [1:0] rd_err, wr_err;

    dma_rr_channel #(.ADDR_W(ADDR_WIDTH), .SIZE_W(SIZE_WIDTH)) u_rd (
        .clk       (clk),
        .rst       (rst),
        .req_go    (req_rd_go),
        .req_addr  (req_rd_addr),
        .req_size  (req_rd_size),
        .beat_acc  (dma_rd_en),
        .dma_done  (dma_rd_done),
        .xfer_open (rd_open),
        .grant     (rd_g),
        .dma_go    (dma_rd_go),
        .dma_addr  (dma_rd_addr),
        .dma_size  (dma_rd_size),
        .done      (req_rd_done),
        .err       (rd_err)
    );

    dma_rr_channel #(.ADDR_W(ADDR_WIDTH), .SIZE_W(SIZE_WIDTH)) u_wr (
        .clk       (clk),
        .rst       (rst),
        .req_go    (req_wr_go),
        .req_addr  (req_wr_addr),
        .req_size  (req_wr_size),
        .beat_acc  (dma_wr_en),
        .dma_done  (dma_wr_done),
        .xfer_open (wr_open),
        .grant     (wr_g),
        .dma_go    (dma_wr_go),
        .dma_addr  (dma_wr_addr),
        .dma_size  (dma_wr_size),
        .done      (req_wr_done),
        .err       (wr_err)
    );

    // Read side: expose data availability and forward pops only for the granted requester.
    always_comb begin
        req_rd_empty = 2'b11;
        if (rd_open && !dma_rd_empty)
            req_rd_empty[rd_g] = 1'b0;
        dma_rd_en = rd_open & req_rd_en[rd_g] & ~dma_rd_empty;
    end

    // Write side: expose space and forward pushes and data only for the granted requester.
    always_comb begin
        req_wr_full = 2'b11;
        if (wr_open && !dma_wr_full)
            req_wr_full[wr_g] = 1'b0;
        dma_wr_en   = wr_open & req_wr_en[wr_g] & ~dma_wr_full;
        dma_wr_data = req_wr_data[wr_g];
    end

    assign req_rd_data = dma_rd_data;
    assign req_err     = rd_err | wr_err;

endmodule
